// File: rtl/tone_arbiter.sv
// Fixed-priority arbiter sharing one piezo tone generator between an alert port (0) and a melody port (1).
// Optional feature: define TONE_ARB_PREEMPT_EN to let an alert request abort a playing melody note.
module tone_arbiter #(
  parameter int PW      = 17,
  parameter int DW      = 27,
  parameter int GAP_CYC = 1000000
) (
  input  logic          clk,
  input  logic          rb,
  input  logic          req0,
  input  logic [PW-1:0] period0,
  input  logic [DW-1:0] dur0,
  output logic          ack0,
  output logic          done0,
  input  logic          req1,
  input  logic [PW-1:0] period1,
  input  logic [DW-1:0] dur1,
  output logic          ack1,
  output logic          done1,
  output logic          abort1,
  output logic          buzzer,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYC - 1);

  state_t        state_q;
  logic [PW-1:0] period_q;
  logic [DW-1:0] dur_q;
  logic [PW-1:0] tone_cnt_q;
  logic [DW-1:0] dur_cnt_q;
  logic [DW-1:0] gap_cnt_q;
  logic          ack0_q, ack1_q, done0_q, done1_q, abort1_q;
  logic          buzzer_q, busy_q, owner_q;

  logic          grant_idle;
  logic          preempt;
  logic          grant;
  logic [PW-1:0] g_period;
  logic [DW-1:0] g_dur_raw;
  logic [DW-1:0] g_dur;

  // Port 0 always wins; during a preemption req0 is high, so the same mux serves both cases.
  assign g_period   = req0 ? period0 : period1;
  assign g_dur_raw  = req0 ? dur0 : dur1;
  assign g_dur      = (g_dur_raw == '0) ? DW'(1) : g_dur_raw;
  assign grant_idle = (state_q == IDLE) && (req0 || req1);

`ifdef TONE_ARB_PREEMPT_EN
  assign preempt = (state_q == PLAY) && owner_q && req0;
`else
  assign preempt = 1'b0;
`endif

  assign grant = grant_idle || preempt;

  always_ff @(posedge clk or posedge rb) begin
    if (rb) begin
      state_q    <= IDLE;
      period_q   <= '0;
      dur_q      <= '0;
      tone_cnt_q <= '0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      abort1_q   <= 1'b0;
      buzzer_q   <= 1'b1;
      busy_q     <= 1'b0;
      owner_q    <= 1'b0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      abort1_q <= 1'b0;
      if (grant) begin
        state_q    <= PLAY;
        period_q   <= g_period;
        dur_q      <= g_dur;
        tone_cnt_q <= '0;
        dur_cnt_q  <= '0;
        ack0_q     <= req0;
        ack1_q     <= ~req0;
        owner_q    <= ~req0;
        abort1_q   <= preempt;
        buzzer_q   <= (g_period == '0);
        busy_q     <= 1'b1;
      end else begin
        case (state_q)
          PLAY: begin
            dur_cnt_q <= dur_cnt_q + 1'b1;
            if (dur_cnt_q == dur_q - 1'b1) begin
              done0_q   <= ~owner_q;
              done1_q   <= owner_q;
              buzzer_q  <= 1'b1;
              gap_cnt_q <= '0;
              state_q   <= GAP;
            end else if (period_q != '0) begin
              if (tone_cnt_q == period_q - 1'b1) begin
                buzzer_q   <= ~buzzer_q;
                tone_cnt_q <= '0;
              end else begin
                tone_cnt_q <= tone_cnt_q + 1'b1;
              end
            end
          end
          GAP: begin
            buzzer_q <= 1'b1;
            if (gap_cnt_q == GAP_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
          default: begin
            buzzer_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign abort1 = abort1_q;
  assign buzzer = buzzer_q;
  assign busy   = busy_q;
  assign owner  = owner_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Self-checking bench for tone_arbiter: directed scenarios plus randomized traffic against a timing model.
module tb_tone_arbiter;

  localparam int PW = 8;
  localparam int DW = 10;
  localparam int G  = 4;
`ifdef TONE_ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rb  = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [PW-1:0] period0 = '0, period1 = '0;
  logic [DW-1:0] dur0 = '0, dur1 = '0;
  logic          ack0, ack1, done0, done1, abort1, buzzer, busy, owner;

  int checks = 0;
  int passes = 0;

  tone_arbiter #(.PW(PW), .DW(DW), .GAP_CYC(G)) dut (
    .clk(clk), .rb(rb),
    .req0(req0), .period0(period0), .dur0(dur0), .ack0(ack0), .done0(done0),
    .req1(req1), .period1(period1), .dur1(dur1), .ack1(ack1), .done1(done1),
    .abort1(abort1), .buzzer(buzzer), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    #2 rb = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rb = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rb = 1'b1;
    #1;
    checks++;
    if ({buzzer, busy, owner, ack0, ack1, done0, done1, abort1} !== 8'b1000_0000)
      $display("FAIL reset_async got=%b want=10000000",
               {buzzer, busy, owner, ack0, ack1, done0, done1, abort1});
    else passes++;
    @(negedge clk);
    rb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({buzzer, busy, owner, ack0, ack1, done0, done1, abort1} !== 8'b1000_0000)
        $display("FAIL reset_idle cyc=%0d got=%b want=10000000", k,
                 {buzzer, busy, owner, ack0, ack1, done0, done1, abort1});
      else passes++;
    end
  endtask

  task automatic test_single_note();
    logic exp_b [18] = '{0,0,0,1,1,1,0,0,0,1,1,1,1,1,1,1,1,0};
    logic [3:0] exp_v;
    do_reset();
    req1 = 1'b1; period1 = 8'd3; dur1 = 10'd12;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); @(negedge clk);
      exp_v = {exp_b[k], (k != 16), (k == 0 || k == 17), (k == 12)};
      checks++;
      if ({buzzer, busy, ack1, done1} !== exp_v)
        $display("FAIL single k=%0d {buz,busy,ack1,done1} got=%b want=%b", k,
                 {buzzer, busy, ack1, done1}, exp_v);
      else passes++;
    end
    req1 = 1'b0;
  endtask

  task automatic test_simultaneous();
    int n_done0 = 0, n_done1 = 0;
    logic [4:0] exp_v;
    do_reset();
    req0 = 1'b1; period0 = 8'd2; dur0 = 10'd6;
    req1 = 1'b1; period1 = 8'd1; dur1 = 10'd3;
    for (int k = 0; k < 21; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) req0 = 1'b0;
      if (k == 11) req1 = 1'b0;
      n_done0 += int'(done0);
      n_done1 += int'(done1);
      exp_v = {(k >= 11), (k == 0), (k == 11), (k == 6), (k == 14)};
      checks++;
      if ({owner, ack0, ack1, done0, done1} !== exp_v)
        $display("FAIL simul k=%0d {own,ack0,ack1,done0,done1} got=%b want=%b", k,
                 {owner, ack0, ack1, done0, done1}, exp_v);
      else passes++;
    end
    checks++;
    if (n_done0 != 1 || n_done1 != 1)
      $display("FAIL simul_done_count got=%0d/%0d want=1/1", n_done0, n_done1);
    else passes++;
  endtask

  task automatic test_silent_zero();
    logic [3:0] exp_v;
    do_reset();
    req0 = 1'b1; period0 = 8'd0; dur0 = 10'd0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) req0 = 1'b0;
      exp_v = {1'b1, (k < 5), (k == 0), (k == 1)};
      checks++;
      if ({buzzer, busy, ack0, done0} !== exp_v)
        $display("FAIL silent k=%0d {buz,busy,ack0,done0} got=%b want=%b", k,
                 {buzzer, busy, ack0, done0}, exp_v);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_play();
    int bad = 0;
    do_reset();
    req1 = 1'b1; period1 = 8'd2; dur1 = 10'd20;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) req1 = 1'b0;
    end
    checks++;
    if ({buzzer, busy} !== 2'b01)
      $display("FAIL midplay_pre {buz,busy} got=%b want=01", {buzzer, busy});
    else passes++;
    #2 rb = 1'b1;
    #1;
    checks++;
    if ({buzzer, busy, owner, done1} !== 4'b1000)
      $display("FAIL midplay_async {buz,busy,own,done1} got=%b want=1000",
               {buzzer, busy, owner, done1});
    else passes++;
    @(negedge clk);
    rb = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); @(negedge clk);
      if (done0 || done1 || busy || ack0 || ack1 || !buzzer) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL midplay_after bad_cycles got=%0d want=0", bad);
    else passes++;
  endtask

`ifdef TONE_ARB_PREEMPT_EN
  task automatic test_preempt();
    logic [5:0] exp_v;
    logic       eb;
    int         j;
    do_reset();
    req1 = 1'b1; period1 = 8'd5; dur1 = 10'd100;
    for (int k = 0; k < 47; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 0) req1 = 1'b0;
      if (k < 30) begin
        eb = ((k / 5) % 2) != 0;
        exp_v = {eb, 1'b1, (k == 0), 1'b0, 1'b0, 1'b0};
      end else begin
        j = k - 30;
        eb = (j >= 10) ? 1'b1 : (((j / 4) % 2) != 0);
        exp_v = {eb, 1'b0, 1'b0, (j == 0), (j == 0), (j == 10)};
      end
      checks++;
      if ({buzzer, owner, ack1, ack0, abort1, done0} !== exp_v || done1 !== 1'b0)
        $display("FAIL preempt k=%0d {buz,own,ack1,ack0,abort1,done0} got=%b want=%b done1=%b", k,
                 {buzzer, owner, ack1, ack0, abort1, done0}, exp_v, done1);
      else passes++;
      if (k == 29) begin req0 = 1'b1; period0 = 8'd4; dur0 = 10'd10; end
      if (k == 30) req0 = 1'b0;
    end
  endtask
`endif

  // Reference: each note is a (start, period, dur, owner) record; outputs follow from elapsed cycles.
  task automatic test_random();
    int   t = 0;
    bit   have = 0, mo = 0, mabort = 0;
    int   ms = 0, mp = 0, md = 0, mfree = 0;
    int   k;
    logic e_buz, e_busy, e_ack0, e_ack1, e_done0, e_done1;
    logic [7:0] exp_v, got_v;
    bit   gnt;
    do_reset();
    e_ack0 = 0; e_ack1 = 0;
    for (int n = 0; n < 3000; n++) begin
      if (req0) begin
        if (e_ack0) begin
          if ($urandom_range(0, 1) == 0) req0 = 1'b0;
          else begin period0 = PW'($urandom_range(0, 4)); dur0 = DW'($urandom_range(0, 12)); end
        end else if ($urandom_range(0, 99) < 3) req0 = 1'b0;
      end else if ($urandom_range(0, 99) < 6) begin
        req0 = 1'b1; period0 = PW'($urandom_range(0, 4)); dur0 = DW'($urandom_range(0, 12));
      end
      if (req1) begin
        if (e_ack1) begin
          if ($urandom_range(0, 1) == 0) req1 = 1'b0;
          else begin period1 = PW'($urandom_range(0, 4)); dur1 = DW'($urandom_range(0, 12)); end
        end else if ($urandom_range(0, 99) < 3) req1 = 1'b0;
      end else if ($urandom_range(0, 99) < 12) begin
        req1 = 1'b1; period1 = PW'($urandom_range(0, 4)); dur1 = DW'($urandom_range(0, 12));
      end
      @(posedge clk);
      mabort = 0;
      gnt = 0;
      if (PRE && have && mo && req0 && t > ms && t <= ms + md) begin
        mabort = 1; gnt = 1;
      end else if (t >= mfree && (req0 || req1)) gnt = 1;
      if (gnt) begin
        have = 1; ms = t; mo = !req0;
        mp = req0 ? int'(period0) : int'(period1);
        md = req0 ? int'(dur0) : int'(dur1);
        if (md == 0) md = 1;
        mfree = t + md + G + 1;
      end
      if (!have) begin
        exp_v = 8'b1000_0000;
        e_ack0 = 0; e_ack1 = 0;
      end else begin
        k = t - ms;
        if (k == 0) e_buz = (mp == 0);
        else if (k < md) e_buz = (mp == 0) ? 1'b1 : (((k / mp) % 2) != 0);
        else e_buz = 1'b1;
        e_busy  = (k < md + G);
        e_ack0  = (k == 0) && !mo;
        e_ack1  = (k == 0) && mo;
        e_done0 = (k == md) && !mo;
        e_done1 = (k == md) && mo;
        exp_v = {e_buz, e_busy, mo, e_ack0, e_ack1, e_done0, e_done1, mabort};
      end
      @(negedge clk);
      got_v = {buzzer, busy, owner, ack0, ack1, done0, done1, abort1};
      checks++;
      if (got_v !== exp_v)
        $display("FAIL random t=%0d {buz,busy,own,ack0,ack1,done0,done1,abort1} got=%b want=%b",
                 t, got_v, exp_v);
      else passes++;
      t++;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_simultaneous();
    test_silent_zero();
    test_reset_mid_play();
`ifdef TONE_ARB_PREEMPT_EN
    test_preempt();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tone_arbiter.md
# tone_arbiter

Shares the single piezo buzzer tone generator between two note sources: a high-priority alert source (port 0) and the melody sequencer (port 1). Each source requests a note as a half-period and a duration in clock cycles. The block grants by fixed priority, then generates the square wave for the programmed duration. It enforces an inter-note silence gap and reports acceptance and completion to the owner. It sits between the note sources and the `buzzer` pin. The buzzer idles high (silent).

## Interface
- `PW`, 17: width of half-period fields, in clock cycles.
- `DW`, 27: width of duration fields, in clock cycles.
- `GAP_CYC`, 1000000: silence cycles after every note; legal range 1 to 2^DW−1.

Ports:
- `clk`, in, 1: system clock.
- `rb`, in, 1: reset, asynchronous, active-high.
- `req0`, in, 1: alert source requests a note.
- `period0`, in, PW: alert half-period; 0 means a silent note.
- `dur0`, in, DW: alert duration; 0 is treated as 1.
- `ack0`, out, 1: one-cycle pulse; alert note accepted and its fields latched.
- `done0`, out, 1: one-cycle pulse; alert note finished.
- `req1`, `period1`, `dur1`, `ack1`, `done1`: same as port 0, for the melody source.
- `abort1`, out, 1: one-cycle pulse; melody note preempted. Active only with the macro; otherwise tied 0.
- `buzzer`, out, 1: square-wave output; 1 when silent.
- `busy`, out, 1: high in PLAY and GAP.
- `owner`, out, 1: port index of the current or last grant.

## Operation
- States are IDLE, PLAY and GAP. All outputs are registered.
- Reset values: state IDLE, `buzzer`=1, `ack*`=0, `done*`=0, `abort1`=0, `busy`=0, `owner`=0, all counters 0. Reset mid-note discards the note; no `done` is issued.
- IDLE: requests are sampled only in this state.
  - `req0` wins over `req1` (fixed priority). A continuous `req0` starves port 1; this is accepted.
  - On grant:
    - Latch the winner's period and duration (0 becomes 1).
    - Set `owner` and pulse `ack`.
    - Clear both counters.
    - Set `buzzer` to 0 if period≠0, else 1.
    - Go to PLAY.
- PLAY: the duration counter increments on every edge.
  - Tone counter, when period≠0: if it equals period−1, toggle `buzzer` and clear; otherwise increment.
  - Silent note: `buzzer` held at 1.
  - On the edge where the duration counter equals dur−1: pulse the owner's `done`, force `buzzer`=1, go to GAP.
- GAP: `buzzer`=1; the gap counter increments. On the edge where it equals GAP_CYC−1, go to IDLE.
- Request semantics:
  - Fields must be stable while `req` is high and until `ack`.
  - Holding `req` high after `ack` queues another note with the then-current fields at the next IDLE.
  - Dropping `req` before a grant withdraws it; no `ack` is issued.
- Both requests in the same IDLE cycle: only `ack0` pulses; `req1` remains pending.

## Timing
- Grant latency: `req` high in an IDLE cycle gives `ack` high in the next cycle. PLAY begins that same cycle.
- PLAY lasts exactly dur cycles. `done` is high in the first GAP cycle.
- `buzzer` edges occur every period cycles after the grant edge: at E_p, E_2p, and so on. Half-period = period cycles.
- GAP lasts exactly GAP_CYC cycles, followed by at least one IDLE cycle.
- Back-to-back grant spacing = dur + GAP_CYC + 1 cycles.
- Arithmetic: counters are unsigned, PW/DW bits wide. Comparisons use equality only; a counter never wraps, because it clears or the state changes at the match.

## Configuration
- `TONE_ARB_PREEMPT_EN` defined:
  - In PLAY with `owner`=1, `req0` high aborts the melody note on that edge: `abort1` pulses, `done1` does not.
  - The alert is then granted immediately, with no GAP: `ack0` pulses on that edge and a new PLAY starts.
  - An alert note (`owner`=0) is never preempted.
  - Preemption is checked only in PLAY. In GAP, `req0` waits for IDLE.
- Macro not defined: no preemption; `abort1` is constant 0.

## Test plan
- Reset and idle: with `rb` pulsed mid-cycle and no requests → `buzzer`=1, `busy`=0, all pulses 0.
- Single note, GAP_CYC=4: `req1`, period1=3, dur1=12.
  - `ack1` one cycle after sampling.
  - `buzzer` goes 0, then toggles 1/0/1 at E3/E6/E9.
  - `done1` and `buzzer`=1 after E12.
  - Next grant no earlier than E17.
- Simultaneous `req0`/`req1` with held requests → `ack0` first, then `ack1` after dur0+GAP_CYC+1 cycles. Each port gets exactly one `done`.
- Silent and zero-duration notes: period0=0, dur0=0 → `buzzer` stays 1, `done0` one cycle after `ack0`.
- Reset mid-PLAY: assert `rb` at cycle 5 of dur=20 → `buzzer`=1 immediately, no `done`, state IDLE.
- With `TONE_ARB_PREEMPT_EN`: melody note period=5, dur=100; `req0` at cycle 30 → `abort1` and `ack0` on the same edge, no `done1`, alert tone starts.
